fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the five-stage RISC-V core. Holds the program counter, selects sequential or redirected next PC, and presents the fetched instruction to decode. Consumes the hazard unit's stall and flush controls, and supplies the decode-stage instruction fields from which the hazard unit derives Rs1D/Rs2D. Also keeps a sticky misaligned-target flag and two 32-bit performance counters.

---
 rtl/core_pkg.sv | 15 +
 rtl/if_id_reg.sv | 49 ++++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Core-wide constants and helpers shared by fetch, decode and the hazard logic.
package core_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ILEN      = 32;
    localparam int unsigned CNT_W     = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush-over-stall priority and bubble insertion.
// Ports:
//   clk, rst            clock, async active-high reset
//   stall, flush        hold contents / replace contents with a bubble
//   instr_f, pc_f,
//   pc_plus4_f          fetch-side values captured on a normal edge
//   instr_d, pc_d,
//   pc_plus4_d, valid_d decode-side registered outputs
module if_id_reg
    import core_pkg::*;
#(
    parameter int unsigned XLEN      = core_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [31:0]     instr_f,
    input  logic [XLEN-1:0] pc_f,
    input  logic [XLEN-1:0] pc_plus4_f,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);

    // A bubble carries a NOP with zeroed PCs so nothing downstream mistakes it
    // for a real instruction; flush is checked before stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (flush) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (!stall) begin
            instr_d    <= instr_f;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_plus4_f;
            valid_d    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register,
// sticky misaligned-redirect flag and saturating stall/flush counters.
// Ports:
//   clk, rst              clock, async active-high reset
//   StallF, StallD,
//   FlushD                hazard-unit controls
//   PCSrcE, PCTargetE     redirect request and target from execute
//   PCF                   fetch address to instruction memory
//   InstrF                combinational instruction-memory read data
//   InstrD, PCD,
//   PCPlus4D, ValidD      decode-stage instruction and PCs
//   MisalignErr           sticky: redirect to a non word-aligned target seen
//   StallCount,
//   FlushCount            saturating performance counters
module fetch_stage
    import core_pkg::*;
#(
    parameter int unsigned      XLEN      = core_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(core_pkg::RESET_PC),
    parameter logic [31:0]      NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] PCF,
    input  logic [31:0]     InstrF,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            MisalignErr,
    output logic [31:0]     StallCount,
    output logic [31:0]     FlushCount
);

    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] pc_next;
    logic            stall_event;
    logic            misalign_event;

    // Sequential address wraps silently at the top of the address space.
    assign pc_plus4_f = PCF + XLEN'(4);

    // Redirect beats stall so a resolved taken branch is never dropped.
    always_comb begin
        pc_next = pc_plus4_f;
        if (PCSrcE) begin
            pc_next = PCTargetE;
        end else if (StallF) begin
            pc_next = PCF;
        end
    end

    // A stall cycle only counts when the PC really held (no redirect).
    assign stall_event    = StallF & ~PCSrcE;
    assign misalign_event = PCSrcE & (PCTargetE[1:0] != 2'b00);

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCF <= RESET_PC;
        end else begin
            PCF <= pc_next;
        end
    end

    // Sticky misaligned-target flag; the target itself is used unmodified.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MisalignErr <= 1'b0;
        end else if (misalign_event) begin
            MisalignErr <= 1'b1;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall_event) begin
                StallCount <= sat_inc(StallCount);
            end
            if (FlushD) begin
                FlushCount <= sat_inc(FlushCount);
            end
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .stall      (StallD),
        .flush      (FlushD),
        .instr_f    (InstrF),
        .pc_f       (PCF),
        .pc_plus4_f (pc_plus4_f),
        .instr_d    (InstrD),
        .pc_d       (PCD),
        .pc_plus4_d (PCPlus4D),
        .valid_d    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table-driven vectors through a
// scoreboard queue, plus hand sequences for async reset and PC wrap-around.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, MisalignErr;
    logic [31:0] StallCount, FlushCount;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .PCF         (PCF),
        .InstrF      (InstrF),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD),
        .MisalignErr (MisalignErr),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount)
    );

    // Instruction memory: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    assign InstrF = mem_word(PCF);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        stall_f, stall_d, flush_d, pcsrc_e;
        logic [31:0] target;
        logic [31:0] pcf, pcd;
        logic        valid, mis;
        logic [31:0] scnt, fcnt;
    } vec_t;

    typedef struct {
        logic [31:0] pcf, instrd, pcd, pc4d;
        logic        valid, mis;
        logic [31:0] scnt, fcnt;
        int          idx;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[22];

    function automatic vec_t mk(input logic sf, input logic sd, input logic fd, input logic ps,
                                input logic [31:0] tg, input logic [31:0] pcf, input logic [31:0] pcd,
                                input logic v, input logic m, input logic [31:0] sc, input logic [31:0] fc);
        vec_t r;
        r.stall_f = sf; r.stall_d = sd; r.flush_d = fd; r.pcsrc_e = ps; r.target = tg;
        r.pcf = pcf; r.pcd = pcd; r.valid = v; r.mis = m; r.scnt = sc; r.fcnt = fc;
        return r;
    endfunction

    function automatic exp_t to_exp(input vec_t v, input int idx);
        exp_t e;
        e.pcf    = v.pcf;
        e.pcd    = v.pcd;
        e.valid  = v.valid;
        e.instrd = v.valid ? mem_word(v.pcd) : NOP;
        e.pc4d   = v.valid ? v.pcd + 32'd4 : 32'd0;
        e.mis    = v.mis;
        e.scnt   = v.scnt;
        e.fcnt   = v.fcnt;
        e.idx    = idx;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check($sformatf("%s PCF", tag),         PCF,                e.pcf);
        check($sformatf("%s InstrD", tag),      InstrD,             e.instrd);
        check($sformatf("%s PCD", tag),         PCD,                e.pcd);
        check($sformatf("%s PCPlus4D", tag),    PCPlus4D,           e.pc4d);
        check($sformatf("%s ValidD", tag),      {31'd0, ValidD},      {31'd0, e.valid});
        check($sformatf("%s MisalignErr", tag), {31'd0, MisalignErr}, {31'd0, e.mis});
        check($sformatf("%s StallCount", tag),  StallCount,         e.scnt);
        check($sformatf("%s FlushCount", tag),  FlushCount,         e.fcnt);
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd, input logic ps,
                         input logic [31:0] tg);
        StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tg;
    endtask

    exp_t e;
    exp_t rst_exp;

    initial begin
        //        sf sd fd ps  target         PCF           PCD           V  M  stall fl
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,   32'h004, 32'h000, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,   32'h008, 32'h004, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,   32'h00C, 32'h008, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,   32'h010, 32'h00C, 1, 0, 0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 32'h0,   32'h010, 32'h00C, 1, 0, 1, 0);
        vecs[5]  = mk(1, 1, 0, 0, 32'h0,   32'h010, 32'h00C, 1, 0, 2, 0);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,   32'h014, 32'h010, 1, 0, 2, 0);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0,   32'h018, 32'h014, 1, 0, 2, 0);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,   32'h01C, 32'h018, 1, 0, 2, 0);
        vecs[9]  = mk(0, 0, 0, 0, 32'h0,   32'h020, 32'h01C, 1, 0, 2, 0);
        vecs[10] = mk(0, 0, 1, 1, 32'h100, 32'h100, 32'h000, 0, 0, 2, 1);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,   32'h104, 32'h100, 1, 0, 2, 1);
        vecs[12] = mk(1, 1, 1, 1, 32'h040, 32'h040, 32'h000, 0, 0, 2, 2);
        vecs[13] = mk(0, 0, 0, 0, 32'h0,   32'h044, 32'h040, 1, 0, 2, 2);
        vecs[14] = mk(0, 0, 1, 1, 32'h102, 32'h102, 32'h000, 0, 1, 2, 3);
        vecs[15] = mk(0, 0, 0, 0, 32'h0,   32'h106, 32'h102, 1, 1, 2, 3);
        vecs[16] = mk(0, 0, 0, 0, 32'h0,   32'h10A, 32'h106, 1, 1, 2, 3);
        vecs[17] = mk(1, 0, 0, 0, 32'h0,   32'h10A, 32'h10A, 1, 1, 3, 3);
        vecs[18] = mk(0, 0, 0, 0, 32'h0,   32'h10E, 32'h10A, 1, 1, 3, 3);
        vecs[19] = mk(0, 1, 0, 0, 32'h0,   32'h112, 32'h10A, 1, 1, 3, 3);
        vecs[20] = mk(0, 0, 0, 0, 32'h0,   32'h116, 32'h112, 1, 1, 3, 3);
        vecs[21] = mk(0, 0, 0, 0, 32'h0,   32'h11A, 32'h116, 1, 1, 3, 3);

        rst_exp.pcf = 32'h0; rst_exp.instrd = NOP; rst_exp.pcd = 32'h0; rst_exp.pc4d = 32'h0;
        rst_exp.valid = 1'b0; rst_exp.mis = 1'b0; rst_exp.scnt = 32'd0; rst_exp.fcnt = 32'd0;
        rst_exp.idx = -1;

        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("reset", rst_exp);

        // Table-driven run through the scoreboard.
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].stall_f, vecs[i].stall_d, vecs[i].flush_d, vecs[i].pcsrc_e, vecs[i].target);
            sb.push_back(to_exp(vecs[i], i));
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard: got empty queue expected entry %0d", i);
            end else begin
                e = sb.pop_front();
                check_all($sformatf("vec%0d", e.idx), e);
            end
        end
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // Async reset mid-cycle while stalled at PCF=0x80.
        drive(0, 0, 1, 1, 32'h080);
        @(posedge clk); #1;
        check("redir80 PCF", PCF, 32'h080);
        drive(1, 1, 0, 0, 32'h0);
        @(posedge clk); #1;
        check("stall80 PCF", PCF, 32'h080);
        check("stall80 StallCount", StallCount, 32'd4);
        check("stall80 FlushCount", FlushCount, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", rst_exp);
        @(posedge clk); #1;
        check_all("rst_held", rst_exp);
        @(negedge clk);
        rst = 1'b0;

        // Redirect near the top of memory, then the +4 wraps to zero.
        drive(0, 0, 1, 1, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check("wrap redir PCF", PCF, 32'hFFFF_FFFC);
        check("wrap redir Misalign", {31'd0, MisalignErr}, 32'd0);
        check("wrap redir FlushCount", FlushCount, 32'd1);
        drive(0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        check("wrap PCF", PCF, 32'h0000_0000);
        check("wrap PCD", PCD, 32'hFFFF_FFFC);
        check("wrap PCPlus4D", PCPlus4D, 32'h0000_0000);
        check("wrap InstrD", InstrD, mem_word(32'hFFFF_FFFC));
        check("wrap ValidD", {31'd0, ValidD}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
